// File: rtl/univ_shift_reg_if.sv
// Bundles the control, data and status signals of univ_shift_reg.
// The master side drives the controls and the slave side (the register) drives the status.
interface univ_shift_reg_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] pdata;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, sin_l, sin_r, pdata, start, count,
        input  q, nq, sout_l, sout_r, busy, done
    );

    modport slave (
        input  en, mode, sin_l, sin_r, pdata, start, count,
        output q, nq, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step operations and a counted burst of shifts/rotates.
// A burst latches the operation and its count, then applies it once per clock edge.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    univ_shift_reg_if.slave   bus
);
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [2:0]       r_mode, w_mode_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             w_is_shift;
    logic             w_start_burst;
    logic             w_start_zero;
    logic             w_last;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] d,
        input logic             sl,
        input logic             sr,
        input logic [WIDTH-1:0] pd
    );
        case (op)
            M_SHL:   apply_op = {d[WIDTH-2:0], sl};
            M_SHR:   apply_op = {sr, d[WIDTH-1:1]};
            M_ROL:   apply_op = {d[WIDTH-2:0], d[WIDTH-1]};
            M_ROR:   apply_op = {d[0], d[WIDTH-1:1]};
            M_LOAD:  apply_op = pd;
            M_CLR:   apply_op = '0;
            default: apply_op = d;
        endcase
    endfunction

    // Only shift/rotate modes may start a burst; a zero count just pulses done.
    assign w_is_shift    = (bus.mode == M_SHL) || (bus.mode == M_SHR) ||
                           (bus.mode == M_ROL) || (bus.mode == M_ROR);
    assign w_start_burst = bus.start && w_is_shift && (bus.count != '0);
    assign w_start_zero  = bus.start && w_is_shift && (bus.count == '0);
    assign w_last        = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_burst) w_state_nxt = S_BURST;
            S_BURST: if (w_last)        w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_q_nxt    = r_q;
        w_mode_nxt = r_mode;
        w_cnt_nxt  = r_cnt;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_burst) begin
                    w_mode_nxt = bus.mode;
                    w_cnt_nxt  = bus.count;
                    w_busy_nxt = 1'b1;
                end else if (w_start_zero) begin
                    w_done_nxt = 1'b1;
                end else if (bus.en) begin
                    w_q_nxt = apply_op(bus.mode, r_q, bus.sin_l, bus.sin_r, bus.pdata);
                end
            end
            S_BURST: begin
                w_q_nxt    = apply_op(r_mode, r_q, bus.sin_l, bus.sin_r, r_q);
                w_cnt_nxt  = r_cnt - CNT_W'(1);
                w_busy_nxt = !w_last;
                w_done_nxt = w_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_mode <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_mode <= w_mode_nxt;
            r_cnt  <= w_cnt_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign bus.q      = r_q;
    assign bus.nq     = ~r_q;
    assign bus.sout_l = r_q[WIDTH-1];
    assign bus.sout_r = r_q[0];
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: expected state per edge is queued when stimulus is driven
// and checked #1 after the edge that should produce it.
module tb_univ_shift_reg;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    univ_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the expectation, clock one edge, then pop and compare every output.
    task automatic cyc(input string tag, input logic [7:0] q, input logic busy, input logic done);
        exp_t e;
        exp_t s;
        e.tag = tag; e.q = q; e.busy = busy; e.done = done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        s = sb.pop_front();
        chk_byte({s.tag, ".q"},  bus.q,  s.q);
        chk_byte({s.tag, ".nq"}, bus.nq, ~s.q);
        chk_bit({s.tag, ".sout_l"}, bus.sout_l, s.q[7]);
        chk_bit({s.tag, ".sout_r"}, bus.sout_r, s.q[0]);
        chk_bit({s.tag, ".busy"}, bus.busy, s.busy);
        chk_bit({s.tag, ".done"}, bus.done, s.done);
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b1; bus.mode = 3'b101; bus.pdata = 8'hFF;
        bus.sin_l = 1'b0; bus.sin_r = 1'b0; bus.start = 1'b1; bus.count = 4'd3;
        cyc("reset", 8'h00, 1'b0, 1'b0);

        rst = 1'b0; bus.start = 1'b0; bus.pdata = 8'hA5;
        cyc("load_a5", 8'hA5, 1'b0, 1'b0);
        bus.mode = 3'b001; bus.sin_l = 1'b1;
        cyc("shl_1", 8'h4B, 1'b0, 1'b0);

        bus.mode = 3'b101; bus.pdata = 8'h81;
        cyc("load_81", 8'h81, 1'b0, 1'b0);
        bus.en = 1'b0; bus.start = 1'b1; bus.mode = 3'b100; bus.count = 4'd3;
        cyc("ror3_start", 8'h81, 1'b1, 1'b0);
        bus.start = 1'b0; bus.mode = 3'b000;
        cyc("ror3_1", 8'hC0, 1'b1, 1'b0);
        cyc("ror3_2", 8'h60, 1'b1, 1'b0);
        cyc("ror3_3", 8'h30, 1'b0, 1'b1);
        cyc("ror3_after", 8'h30, 1'b0, 1'b0);

        bus.start = 1'b1; bus.en = 1'b1; bus.mode = 3'b001; bus.count = 4'd0;
        cyc("cnt0_start", 8'h30, 1'b0, 1'b1);
        bus.start = 1'b0; bus.en = 1'b0;
        cyc("cnt0_after", 8'h30, 1'b0, 1'b0);

        // Eight shift-lefts of 1s from 0x30; mid-burst controls must be ignored.
        bus.start = 1'b1; bus.mode = 3'b001; bus.count = 4'd8; bus.sin_l = 1'b1;
        cyc("shl8_start", 8'h30, 1'b1, 1'b0);
        bus.en = 1'b1; bus.mode = 3'b101; bus.pdata = 8'h00; bus.count = 4'd2;
        cyc("shl8_1", 8'h61, 1'b1, 1'b0);
        cyc("shl8_2", 8'hC3, 1'b1, 1'b0);
        cyc("shl8_3", 8'h87, 1'b1, 1'b0);
        cyc("shl8_4", 8'h0F, 1'b1, 1'b0);
        cyc("shl8_5", 8'h1F, 1'b1, 1'b0);
        cyc("shl8_6", 8'h3F, 1'b1, 1'b0);
        cyc("shl8_7", 8'h7F, 1'b1, 1'b0);
        cyc("shl8_8", 8'hFF, 1'b0, 1'b1);

        bus.en = 1'b0; bus.mode = 3'b010; bus.count = 4'd2; bus.sin_r = 1'b0;
        cyc("restart_on_done", 8'hFF, 1'b1, 1'b0);
        bus.start = 1'b0;
        cyc("shr2_1", 8'h7F, 1'b1, 1'b0);
        cyc("shr2_2", 8'h3F, 1'b0, 1'b1);

        bus.start = 1'b1; bus.mode = 3'b011; bus.count = 4'd5;
        cyc("rol5_start", 8'h3F, 1'b1, 1'b0);
        bus.start = 1'b0;
        cyc("rol5_1", 8'h7E, 1'b1, 1'b0);
        rst = 1'b1;
        cyc("rst_mid_burst", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc("no_done_after_rst", 8'h00, 1'b0, 1'b0);

        bus.en = 1'b1; bus.mode = 3'b101; bus.pdata = 8'h5A;
        cyc("load_5a", 8'h5A, 1'b0, 1'b0);
        bus.start = 1'b1; bus.mode = 3'b110;
        cyc("start_clear", 8'h00, 1'b0, 1'b0);
        bus.start = 1'b0; bus.en = 1'b0;
        cyc("clear_after", 8'h00, 1'b0, 1'b0);

        bus.en = 1'b1; bus.mode = 3'b010; bus.sin_r = 1'b1;
        cyc("shr_sin1", 8'h80, 1'b0, 1'b0);
        bus.mode = 3'b111;
        cyc("hold_111", 8'h80, 1'b0, 1'b0);
        bus.mode = 3'b100;
        cyc("ror_1", 8'h40, 1'b0, 1'b0);
        bus.mode = 3'b011;
        cyc("rol_1", 8'h80, 1'b0, 1'b0);
        bus.mode = 3'b000;
        cyc("hold_000", 8'h80, 1'b0, 1'b0);
        bus.en = 1'b0; bus.mode = 3'b101; bus.pdata = 8'hFF;
        cyc("en0_hold", 8'h80, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
